// File: rtl/param_register_file.sv
// Multi-read, single-write register file with optional zero register and a one-entry-per-cycle clear engine.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through forwarding to the read ports.
module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                ready_q, ready_d;
  logic                wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  // Writes aimed at the hardwired zero entry are dropped silently.
  logic wr_to_zero;
  assign wr_to_zero = ZERO_EN && (wr_addr == '0);

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    ready_d     = ready_q;
    wr_drop_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_waddr_d = wr_addr;
    mem_wdata_d = wr_data;
    if (rst) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_we_d    = 1'b1;
          mem_waddr_d = clr_idx_q;
          mem_wdata_d = '0;
          clr_idx_d   = clr_idx_q + 1'b1;
          wr_drop_d   = we;
          if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
            state_d = READY;
            ready_d = 1'b1;
          end
        end
        READY: begin
          // A write on the clr_req edge still lands; the clear then wipes it.
          mem_we_d = we && !wr_to_zero;
          if (clr_req) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
            ready_d   = 1'b0;
          end
        end
        default: begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    ready_q   <= ready_d;
    wr_drop_q <= wr_drop_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_en;
  assign fwd_en = (state_q == READY) && we && !wr_to_zero;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      assign ra = rd_addr[gi*ADDR_W +: ADDR_W];
      always_comb begin
        rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (fwd_en && (ra == wr_addr)) rv = wr_data;
`endif
        if (!ready_q || (ZERO_EN && (ra == '0))) rv = '0;
      end
      assign rd_data[gi*DATA_W +: DATA_W] = rv;
    end
  endgenerate

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus; checks via immediate assertions.
module tb_param_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data0;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             clr_req;
  logic             ready, ready0;
  logic             wr_drop, wr_drop0;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  param_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .ready(ready), .wr_drop(wr_drop)
  );

  param_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .ready(ready0), .wr_drop(wr_drop0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk(tag, cnt, exp_cycles);
    chk({tag, "_r0"}, ready0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;

    // 1: reset then clear of 32 entries
    tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_drop", wr_drop, 1'b0);
    rst = 1'b0;
    set_rd(0, 5'd5); set_rd(1, 5'd31); set_rd(2, 5'd7);
    #1;
    chk("clear_rd_forced0", rd_data, '0);
    wait_ready("clear_len", 32);
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < NR; k++) set_rd(k, AW'(i));
      #1;
      chk($sformatf("cleared_r%0d", i), {rd_data0, rd_data}, '0);
    end

    // 2: basic write / read on three ports
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_addr = 5'd31; wr_data = 32'h12345678;
    tick();
    we = 1'b0;
    set_rd(0, 5'd5); set_rd(1, 5'd31); set_rd(2, 5'd5);
    #1;
    chk("rw_p0_r5", rd_data[0*DW +: DW], 32'hDEADBEEF);
    chk("rw_p1_r31", rd_data[1*DW +: DW], 32'h12345678);
    chk("rw_p2_r5", rd_data[2*DW +: DW], 32'hDEADBEEF);

    // 3: zero register
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    we = 1'b0;
    set_rd(0, 5'd0);
    #1;
    chk("zero_drop", wr_drop, 1'b0);
    chk("zero_r0_z1", rd_data[0 +: DW], 32'h0);
    chk("zero_r0_z0", rd_data0[0 +: DW], 32'hFFFFFFFF);

    // 4: same-cycle read/write of r7
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    tick();
    wr_data = 32'h2;
    set_rd(0, 5'd7);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_same", rd_data[0 +: DW], 32'h2);
    chk("rdw_same_z0", rd_data0[0 +: DW], 32'h2);
`else
    chk("rdw_same", rd_data[0 +: DW], 32'h1);
    chk("rdw_same_z0", rd_data0[0 +: DW], 32'h1);
`endif
    tick();
    we = 1'b0;
    #1;
    chk("rdw_next", rd_data[0 +: DW], 32'h2);

    // 5: clr_req with a simultaneous write, then a dropped write during clear
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0;
    chk("clr_ready0", ready, 1'b0);
    tick();
    tick();
    we = 1'b1; wr_addr = 5'd1; wr_data = 32'h55;
    tick();
    we = 1'b0;
    chk("clr_drop_pulse", wr_drop, 1'b1);
    chk("clr_drop_pulse_z0", wr_drop0, 1'b1);
    tick();
    chk("clr_drop_end", wr_drop, 1'b0);
    wait_ready("clr_len", 28);
    set_rd(0, 5'd3); set_rd(1, 5'd1); set_rd(2, 5'd7);
    #1;
    chk("clr_r3", rd_data[0*DW +: DW], 32'h0);
    chk("clr_r1_dropped", rd_data0[1*DW +: DW], 32'h0);
    chk("clr_r7", rd_data[2*DW +: DW], 32'h0);

    // 6: reset mid-clear at clr_idx=10 restarts the full sequence
    we = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_ready0", ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready("rst_mid_len", 32);
    set_rd(0, 5'd20);
    #1;
    chk("rst_mid_r20", rd_data[0 +: DW], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
